// File: rtl/uart_rx_axis.sv
// uart_rx_axis
//   UART receiver (8N1 style, LSB first, one stop bit) feeding an AXI-Stream
//   master through a small FIFO. A byte followed by a line-idle gap of
//   IDLE_BITS bit-times is emitted with tlast=1. A byte that is followed by
//   another valid start bit is emitted with tlast=0.
//
// Ports
//   clk            : single clock, rising edge
//   rst_n          : asynchronous active-low reset
//   uart_rx        : serial input, idle high, asynchronous to clk
//   m_axis_tdata   : byte at the FIFO head
//   m_axis_tvalid  : FIFO non-empty
//   m_axis_tready  : downstream accept
//   m_axis_tlast   : head byte closes a packet
//   frame_err      : one-cycle pulse, stop bit sampled as 0
//   overrun        : one-cycle pulse, byte dropped because the FIFO was full
//   dbg_state_o    : receiver FSM state (IDLE=0 START=1 DATA=2 STOP=3 BREAK=4)
//
// Handshake: a beat transfers on a rising clk edge where m_axis_tvalid and
// m_axis_tready are both high; while tvalid is high and tready is low,
// tdata/tlast hold their value and tvalid stays high.
module uart_rx_axis #(
  parameter int CLK_DIV    = 16,
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int IDLE_BITS  = 10
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 uart_rx,
  output logic [DATA_BITS-1:0] m_axis_tdata,
  output logic                 m_axis_tvalid,
  input  logic                 m_axis_tready,
  output logic                 m_axis_tlast,
  output logic                 frame_err,
  output logic                 overrun,
  output logic [2:0]           dbg_state_o
);

  localparam int CNT_W      = $clog2(CLK_DIV);
  localparam int BIT_W      = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam int IDLE_LIMIT = IDLE_BITS * CLK_DIV;
  localparam int IDLE_W     = $clog2(IDLE_LIMIT + 1);
  localparam int PTR_W      = $clog2(FIFO_DEPTH);
  localparam int FCNT_W     = PTR_W + 1;

  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0]  SAMP0     = CNT_W'(CLK_DIV / 2 - 1);
  localparam logic [CNT_W-1:0]  SAMP1     = CNT_W'(CLK_DIV / 2);
  localparam logic [CNT_W-1:0]  MID_PT    = CNT_W'(CLK_DIV / 2 + 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);
  localparam logic [IDLE_W-1:0] IDLE_MAX  = IDLE_W'(IDLE_LIMIT);
  localparam logic [FCNT_W-1:0] FIFO_FULL = FCNT_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } state_e;

  // Synchronizer and edge detect
  logic rx_meta_q, rx_s_q, rx_prev_q;

  // Receiver state
  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [1:0]           samp_q, samp_d;
  logic [BIT_W-1:0]     bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;

  // Pending stage: holds the last good byte until its tlast is known
  logic [DATA_BITS-1:0] pend_data_q, pend_data_d;
  logic                 pend_vld_q, pend_vld_d;
  logic [IDLE_W-1:0]    idle_cnt_q, idle_cnt_d;

  logic frame_err_q, frame_err_d;
  logic overrun_q, overrun_d;

  // FIFO
  logic [DATA_BITS:0]   mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]     head_q, head_d, tail_q, tail_d;
  logic [FCNT_W-1:0]    count_q, count_d;

  logic                 at_mid, vote;
  logic                 push_req, push_last, push_ok, pop;
  logic [DATA_BITS-1:0] push_data;

  // 2-flop synchronizer; rx_prev_q is one cycle behind rx_s_q for edge detect
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= uart_rx;
      rx_s_q    <= rx_meta_q;
      rx_prev_q <= rx_s_q;
    end
  end

  // Two earlier samples are stored; the third is the live rx_s_q at the
  // mid-point, so the vote is ready on the same cycle as the decision.
  assign at_mid = (cnt_q == MID_PT);
  assign vote   = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_s_q) | (samp_q[1] & rx_s_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      samp_q      <= 2'b11;
      bit_idx_q   <= '0;
      shreg_q     <= '0;
      pend_data_q <= '0;
      pend_vld_q  <= 1'b0;
      idle_cnt_q  <= '0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      samp_q      <= samp_d;
      bit_idx_q   <= bit_idx_d;
      shreg_q     <= shreg_d;
      pend_data_q <= pend_data_d;
      pend_vld_q  <= pend_vld_d;
      idle_cnt_q  <= idle_cnt_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    samp_d      = samp_q;
    bit_idx_d   = bit_idx_q;
    shreg_d     = shreg_q;
    pend_data_d = pend_data_q;
    pend_vld_d  = pend_vld_q;
    idle_cnt_d  = idle_cnt_q;
    frame_err_d = 1'b0;
    push_req    = 1'b0;
    push_last   = 1'b0;
    push_data   = pend_data_q;

    // Bit-time counter and sample capture run only inside a frame
    if (state_q == S_START || state_q == S_DATA || state_q == S_STOP) begin
      cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
      if (cnt_q == SAMP0) samp_d[0] = rx_s_q;
      if (cnt_q == SAMP1) samp_d[1] = rx_s_q;
    end

    unique case (state_q)
      S_IDLE: begin
        // Idle gap timer only advances here, so START/BREAK pause it
        if (pend_vld_q) begin
          if (idle_cnt_q == IDLE_MAX) begin
            push_req   = 1'b1;
            push_last  = 1'b1;
            pend_vld_d = 1'b0;
          end else begin
            idle_cnt_d = idle_cnt_q + 1'b1;
          end
        end
        if (rx_prev_q && !rx_s_q) begin
          state_d = S_START;
          cnt_d   = '0;
        end
      end
      S_START: begin
        if (at_mid) begin
          if (vote) begin
            state_d = S_IDLE;
          end else begin
            state_d   = S_DATA;
            bit_idx_d = '0;
            // A new frame is certain, so the pending byte is not a packet end
            if (pend_vld_q) begin
              push_req   = 1'b1;
              push_last  = 1'b0;
              pend_vld_d = 1'b0;
            end
          end
        end
      end
      S_DATA: begin
        if (at_mid) begin
          shreg_d = {vote, shreg_q[DATA_BITS-1:1]};
          if (bit_idx_q == BIT_LAST) begin
            state_d = S_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end
      end
      S_STOP: begin
        if (at_mid) begin
          if (vote) begin
            pend_data_d = shreg_q;
            pend_vld_d  = 1'b1;
            // The mid-point cycle itself counts as the first idle clock
            idle_cnt_d  = IDLE_W'(1);
            state_d     = S_IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        if (rx_s_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FIFO control; a push into a full FIFO is accepted only if a pop frees
  // the slot in the same cycle.
  assign pop     = (count_q != '0) && m_axis_tready;
  assign push_ok = push_req && ((count_q != FIFO_FULL) || pop);

  always_comb begin
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;
    overrun_d = push_req && !push_ok;
    if (pop)     head_d = head_q + 1'b1;
    if (push_ok) tail_d = tail_q + 1'b1;
    case ({push_ok, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      if (push_ok) mem_q[tail_q] <= {push_last, push_data};
    end
  end

  assign m_axis_tvalid = (count_q != '0);
  assign m_axis_tdata  = mem_q[head_q][DATA_BITS-1:0];
  assign m_axis_tlast  = mem_q[head_q][DATA_BITS];
  assign frame_err     = frame_err_q;
  assign overrun       = overrun_q;
  assign dbg_state_o   = state_q;

endmodule
